demux1to16_8bit_reg: RTL
========================

Name: demux1to16_8bit_reg

Overview:
Registered 1-to-16 byte demultiplexer/distributor, the inverse of the 16:1 8-bit bus selector. It takes a single 8-bit input stream with a valid/ready handshake and steers each accepted byte into one of 16 per-channel holding registers. Each channel has its own valid/ack handshake. The destination comes either from an explicit select or from an internal auto-increment pointer (scatter mode). It sits between a shared byte source and 16 independent consumers.

Parameters:
WIDTH, 8, data width of the input and of each output channel
(channel count is fixed at 16; select and pointer are 4 bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
inBus  input  WIDTH  input data byte
in_valid  input  1  source presents a byte on inBus
in_ready  output  1  block accepts the byte this cycle
select  input  4  explicit destination channel; used when auto_mode=0
auto_mode  input  1  1: destination = internal pointer; 0: destination = select
ptr_clr  input  1  synchronous clear of the auto pointer
outBus  output  16*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
out_valid  output  16  channel k holds an unconsumed byte
out_ack  input  16  consumer k takes its byte this cycle
cur_ptr  output  4  current auto pointer value

Behaviour:
- Reset (async, rst=1): outBus all 0, out_valid 0x0000, ptr 0. in_ready evaluates from the reset state, so it is 1.
- Target:
  - tgt = auto_mode ? ptr : select (combinational).
  - ptr is exposed on cur_ptr.
- in_ready = ~out_valid[tgt] | out_ack[tgt]:
  - Combinational from registered state plus out_ack.
  - No dependency on in_valid.
- accept = in_valid & in_ready.
- On accept, at the clock edge:
  - outBus[tgt] <= inBus.
  - out_valid[tgt] <= 1.
  - Latency is 1 cycle: the byte is visible on outBus and out_valid in the cycle after acceptance.
- Channel k ack:
  - If out_valid[k]=1 and out_ack[k]=1, then out_valid[k] <= 0, unless an accept writes channel k in the same cycle. In that case the new data is loaded and out_valid[k] stays 1 (back-to-back refill, no bubble).
- out_ack[k] while out_valid[k]=0 is ignored.
- Multiple channels may be acked in the same cycle; each is handled independently.
- Data retention:
  - Channels that are neither written nor reset keep their outBus value, including after ack.
  - outBus is meaningful only while out_valid=1.
- Full channel, no ack: in_ready=0, so nothing is written and ptr holds. The source stalls; there is no drop and no overwrite.
- Pointer:
  - When auto_mode=1 and accept, ptr <= ptr+1 modulo 16 (15 wraps to 0).
  - ptr never advances without an accept, and never advances in auto_mode=0.
- ptr_clr=1: ptr <= 0 at the next edge.
  - If an auto-mode accept occurs in the same cycle, the byte goes to the old ptr and ptr still becomes 0 (clear wins over increment).
- Switching auto_mode takes effect immediately on tgt. ptr keeps its value across mode changes.
- Reset mid-operation: all pending channel data and valids are discarded immediately, and ptr returns to 0.
- in_valid=0: no state change except acks and ptr_clr.

Test Plan:
1. Reset, then explicit mode: select=5, inBus=0xA5, in_valid for 1 cycle -> next cycle out_valid=0x0020, outBus[5]=0xA5; all other channels 0.
2. Backpressure: channel 3 full and no ack, select=3, in_valid=1 -> in_ready=0, outBus[3] unchanged. Assert out_ack[3] -> in_ready=1 in the same cycle, new byte loaded, out_valid[3] stays 1.
3. Scatter: auto_mode=1, ptr=0, stream 17 bytes 0x10..0x20 with consumers acking every cycle -> channels 0..15 get 0x10..0x1F, channel 0 gets 0x20, cur_ptr ends at 1 (wrap verified).
4. Simultaneous ptr_clr and accept at ptr=9 with inBus=0x77 -> outBus[9]=0x77, cur_ptr=0 next cycle.
5. Stray ack on empty channel 12 plus concurrent ack of valid channel 2 -> out_valid[12] stays 0, out_valid[2] clears, outBus[2] data retained.
6. Assert rst mid-stream with out_valid=0xFFFF, ptr=7 -> immediately out_valid=0, outBus=0, cur_ptr=0, in_ready=1.

Source files
------------

// File: rtl/demux1to16_8bit_reg.sv
// Registered 1-to-16 byte distributor: one valid/ready input stream steered into
// 16 holding registers, each drained by its own valid/ack consumer.
module demux1to16_8bit_reg #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    inBus,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          select,
    input  logic                auto_mode,
    input  logic                ptr_clr,
    output logic [16*WIDTH-1:0] outBus,
    output logic [15:0]         out_valid,
    input  logic [15:0]         out_ack,
    output logic [3:0]          cur_ptr
);

    logic [15:0][WIDTH-1:0] data_q, data_d;
    logic [15:0]            valid_q, valid_d;
    logic [3:0]             ptr_q, ptr_d;
    logic [3:0]             tgt;
    logic                   accept;

    always_comb begin
        tgt      = auto_mode ? ptr_q : select;
        // A full target can still take a byte when its consumer drains it this cycle.
        in_ready = ~valid_q[tgt] | out_ack[tgt];
        accept   = in_valid & in_ready;

        data_d  = data_q;
        valid_d = valid_q & ~out_ack;
        if (accept) begin
            data_d[tgt]  = inBus;
            valid_d[tgt] = 1'b1;
        end

        ptr_d = ptr_q;
        if (ptr_clr) begin
            ptr_d = 4'd0;
        end else if (accept && auto_mode) begin
            ptr_d = ptr_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign outBus    = data_q;
    assign out_valid = valid_q;
    assign cur_ptr   = ptr_q;

endmodule
